mac_host_link: RTL and testbench
================================

Name: mac_host_link

Overview:
- Host-side driver for the bit-serial MAC chip pin protocol.
- Accepts parallel 8-bit operand pairs on a valid/ready interface and serialises them onto the chip's operand pins, then issues START.
- Waits for Finish, deserialises the 20-bit result and carry, and returns them on a valid/ready interface.
- Lives in the FPGA/test-harness wrapper that talks to the chip pins; one clock domain shared with the chip.

Parameters:
- OP_W, 8, operand width in bits (serial frame length).
- RES_W, 20, result width in bits (capture frame length).
- TIMEOUT, 255, maximum WAIT cycles for Finish before aborting; must be ≥1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  OP_W  operand A.
- in_b  in  OP_W  operand B.
- ser_a  out  1  serial operand A bit to chip.
- ser_b  out  1  serial operand B bit to chip.
- ser_valid  out  1  ser_a/ser_b carry a frame bit this cycle.
- start  out  1  one-cycle START pulse to chip.
- finish  in  1  chip Finish; high while result bits stream.
- res_ser  in  1  serial result bit from chip.
- carry_in  in  1  chip carry-out, sampled on the first Finish cycle.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  RES_W  captured result.
- out_carry  out  1  captured carry.
- out_status  out  2  0 = ok, 1 = timeout, 2 = framing error.

Behaviour:
- Reset (async, immediate):
  - State is IDLE and all counters are cleared.
  - ser_a, ser_b, ser_valid, start, out_valid, out_result, out_carry and out_status are all 0.
  - in_ready is 1.
- Asserting reset mid-operation forces every pin low in the same cycle. No partial result is ever presented.
- States: IDLE, SHIFT, STRT, WAIT, CAPT, HOLD. All outputs are registered except in_ready, which is (state == IDLE).
- IDLE:
  - in_valid && in_ready latches in_a/in_b into shift registers and moves to SHIFT.
  - Call the accept edge cycle 0.
- SHIFT (cycles 1..OP_W):
  - ser_valid = 1.
  - ser_a/ser_b = bit k of in_a/in_b on cycle k+1, LSB first.
  - After OP_W bits, go to STRT.
- STRT (cycle OP_W+1):
  - start = 1 for exactly one cycle; ser_valid = 0.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - Each cycle with finish = 0 increments the wait counter.
  - If the counter reaches TIMEOUT: go to HOLD with out_status = 1, out_result = 0, out_carry = 0.
  - The edge that samples finish = 1 captures res_ser as bit 0 and carry_in as out_carry, then goes to CAPT.
- CAPT:
  - Captures bits 1..RES_W-1 on the next RES_W-1 edges, LSB first.
  - finish must stay 1 for the whole frame. If finish is sampled 0 before the last bit: go to HOLD with out_status = 2, out_result = 0, out_carry = 0.
  - On a clean frame: go to HOLD with status 0.
- HOLD:
  - out_valid = 1; out_result, out_carry and out_status are stable until out_valid && out_ready.
  - Then return to IDLE, clearing out_valid.
  - finish/res_ser activity in HOLD or IDLE is ignored.
- Latency: with Finish first sampled high on cycle F, out_valid rises on cycle F+RES_W.
- Throughput: the minimum spacing between accepts is OP_W+3+RES_W cycles plus the chip wait time. There is always at least one IDLE cycle between HOLD and the next accept, so in_valid during HOLD is not accepted.
- finish already high on entry to WAIT is treated as bit 0 on the first WAIT edge. This is legal.
- TIMEOUT counting is saturating; the counter width is clog2(TIMEOUT+1).

Decomposition:
- Package mac_link_pkg holds:
  - the state enum (IDLE, SHIFT, STRT, WAIT, CAPT, HOLD);
  - the status codes ST_OK = 0, ST_TIMEOUT = 1, ST_FRAME = 2;
  - default OP_W/RES_W constants shared with the chip-side model.
- One sub-module, mac_result_sipo: a RES_W-bit serial-in/parallel-out register with a bit counter, clear, shift enable and done flag. The FSM and PISO stay in the top.

Test Plan:
- Basic transaction:
  - Stimulus: in_a = 0xA5, in_b = 0x3C. Responder model raises finish 5 cycles after start and streams 20'h026AC with carry 0.
  - Required: ser_a = 1,0,1,0,0,1,0,1 and ser_b = 0,0,1,1,1,1,0,0 on cycles 1..8; start high on cycle 9 only; out_result = 20'h026AC, out_carry = 0, out_status = 0; out_valid exactly 20 cycles after finish is first sampled.
- Carry/max:
  - Stimulus: in_a = in_b = 0xFF; responder returns 20'hFFFFF with carry 1.
  - Required: out_result = 20'hFFFFF, out_carry = 1, status 0.
- Timeout:
  - Stimulus: TIMEOUT = 16, finish held low.
  - Required: out_valid 16 cycles after the start cycle with status 1 and result 0; the next transaction completes normally.
- Framing:
  - Stimulus: finish drops after 7 result bits.
  - Required: status 2, result 0; a following good transaction returns the correct value.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles in HOLD.
  - Required: outputs stable, in_ready = 0 throughout; after the handshake, in_ready = 1 on the next cycle.
- Reset mid-operation:
  - Stimulus: assert reset on cycle 4 of SHIFT.
  - Required: ser_valid/ser_a/ser_b/start go to 0 without waiting for a clock edge; in_ready = 1; no out_valid after release.

Source files
------------

// File: rtl/mac_link_pkg.sv
// Shared definitions for the host-side MAC pin-protocol link.
// Holds the FSM state encoding, the result status codes and the default
// operand/result frame lengths used by both the host link and the chip model.
package mac_link_pkg;

  localparam int OP_W_DEF  = 8;
  localparam int RES_W_DEF = 20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    STRT  = 3'd2,
    WAIT  = 3'd3,
    CAPT  = 3'd4,
    HOLD  = 3'd5
  } state_e;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_FRAME   = 2'd2;

endpackage

// File: rtl/mac_result_sipo.sv
// Serial-in/parallel-out result register, LSB first.
// Ports:
//   clock, reset  - system clock, async active-high reset
//   clr           - synchronous clear of data and bit count
//   shift_en      - shift bit_in in at the MSB end this cycle
//   bit_in        - serial result bit
//   data          - assembled result (first bit received ends up at bit 0)
//   done          - RES_W bits have been shifted in since the last clear
// RES_W must be at least 2.
module mac_result_sipo
  import mac_link_pkg::*;
#(
  parameter int RES_W = RES_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [RES_W-1:0] data,
  output logic             done
);

  localparam int CNT_W = $clog2(RES_W + 1);

  logic [RES_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      data_d = {bit_in, data_q[RES_W-1:1]};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data = data_q;
  assign done = (cnt_q == CNT_W'(RES_W));

endmodule

// File: rtl/mac_host_link.sv
// Host-side driver for the bit-serial MAC chip pin protocol.
// Accepts an operand pair, shifts it out LSB first on ser_a/ser_b, pulses
// start, waits for finish, collects the serial result and carry, and offers
// them with a status code on a valid/ready output.
// Ports:
//   clock, reset            - system clock, async active-high reset
//   in_valid/in_ready       - operand handshake; in_a/in_b operands
//   ser_a/ser_b/ser_valid   - serial operand frame to the chip
//   start                   - one-cycle START pulse
//   finish/res_ser/carry_in - chip result frame
//   out_valid/out_ready     - result handshake; out_result/out_carry/out_status
//
// state | meaning
// IDLE  | ready for an operand pair (in_ready = 1)
// SHIFT | driving OP_W operand bits, LSB first
// STRT  | start pulse issued, wait timer armed
// WAIT  | waiting for finish, timer running
// CAPT  | collecting result bits 1..RES_W-1
// HOLD  | result presented until out_ready
module mac_host_link
  import mac_link_pkg::*;
#(
  parameter int OP_W    = OP_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  output logic             start,
  input  logic             finish,
  input  logic             res_ser,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_carry,
  output logic [1:0]       out_status
);

  localparam int SH_W   = $clog2(OP_W + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   sh_a_q, sh_a_d;
  logic [OP_W-1:0]   sh_b_q, sh_b_d;
  logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              carry_cap_q, carry_cap_d;

  logic              ser_a_q, ser_a_d;
  logic              ser_b_q, ser_b_d;
  logic              ser_valid_q, ser_valid_d;
  logic              start_q, start_d;
  logic              out_valid_q, out_valid_d;
  logic [RES_W-1:0]  out_result_q, out_result_d;
  logic              out_carry_q, out_carry_d;
  logic [1:0]        out_status_q, out_status_d;

  logic              sipo_clr;
  logic              sipo_shift;
  logic [RES_W-1:0]  sipo_data;
  logic              sipo_done;

  mac_result_sipo #(.RES_W(RES_W)) u_sipo (
    .clock    (clock),
    .reset    (reset),
    .clr      (sipo_clr),
    .shift_en (sipo_shift),
    .bit_in   (res_ser),
    .data     (sipo_data),
    .done     (sipo_done)
  );

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    sh_a_d       = sh_a_q;
    sh_b_d       = sh_b_q;
    sh_cnt_d     = sh_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    carry_cap_d  = carry_cap_q;
    ser_a_d      = 1'b0;
    ser_b_d      = 1'b0;
    ser_valid_d  = 1'b0;
    start_d      = 1'b0;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_status_d = out_status_q;
    sipo_clr     = 1'b0;
    sipo_shift   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sh_a_d   = in_a;
          sh_b_d   = in_b;
          sh_cnt_d = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        ser_valid_d = 1'b1;
        ser_a_d     = sh_a_q[0];
        ser_b_d     = sh_b_q[0];
        sh_a_d      = sh_a_q >> 1;
        sh_b_d      = sh_b_q >> 1;
        sh_cnt_d    = sh_cnt_q + 1'b1;
        if (sh_cnt_q == SH_W'(OP_W - 1)) begin
          state_d = STRT;
        end
      end

      STRT: begin
        start_d     = 1'b1;
        // Timer counts down the remaining finish-low cycles; reaching the
        // last one is the same edge an up-count would hit TIMEOUT.
        wait_cnt_d  = WAIT_W'(TIMEOUT);
        carry_cap_d = 1'b0;
        sipo_clr    = 1'b1;
        state_d     = WAIT;
      end

      WAIT: begin
        if (finish) begin
          sipo_shift  = 1'b1;
          carry_cap_d = carry_in;
          state_d     = CAPT;
        end else if (wait_cnt_q == WAIT_W'(1)) begin
          out_valid_d  = 1'b1;
          out_result_d = '0;
          out_carry_d  = 1'b0;
          out_status_d = ST_TIMEOUT;
          state_d      = HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end

      CAPT: begin
        // Once all RES_W bits are in, finish no longer matters; the result
        // is published one edge after the last bit.
        if (sipo_done) begin
          out_valid_d  = 1'b1;
          out_result_d = sipo_data;
          out_carry_d  = carry_cap_q;
          out_status_d = ST_OK;
          state_d      = HOLD;
        end else if (finish) begin
          sipo_shift = 1'b1;
        end else begin
          out_valid_d  = 1'b1;
          out_result_d = '0;
          out_carry_d  = 1'b0;
          out_status_d = ST_FRAME;
          state_d      = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      sh_cnt_q     <= '0;
      wait_cnt_q   <= '0;
      carry_cap_q  <= 1'b0;
      ser_a_q      <= 1'b0;
      ser_b_q      <= 1'b0;
      ser_valid_q  <= 1'b0;
      start_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      sh_a_q       <= sh_a_d;
      sh_b_q       <= sh_b_d;
      sh_cnt_q     <= sh_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      carry_cap_q  <= carry_cap_d;
      ser_a_q      <= ser_a_d;
      ser_b_q      <= ser_b_d;
      ser_valid_q  <= ser_valid_d;
      start_q      <= start_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_status_q <= out_status_d;
    end
  end

  assign ser_a      = ser_a_q;
  assign ser_b      = ser_b_q;
  assign ser_valid  = ser_valid_q;
  assign start      = start_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_status = out_status_q;

endmodule

// File: tb/tb_mac_host_link.sv
// Directed bench for mac_host_link with a cycle-stepped chip responder.
// Cycle numbering: the accept edge is cycle 0; values are sampled 1 time unit
// after each rising edge, and "cycle n" is what is seen after edge n.
module tb_mac_host_link;

  localparam int OP_W    = 8;
  localparam int RES_W   = 20;
  localparam int TIMEOUT = 16;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic             ser_a;
  logic             ser_b;
  logic             ser_valid;
  logic             start;
  logic             finish;
  logic             res_ser;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic             out_carry;
  logic [1:0]       out_status;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations filled in by do_txn
  logic [0:15]      obs_sa, obs_sb, obs_sv;
  int               start_cyc, start_cnt, valid_cyc;
  logic [RES_W-1:0] got_res;
  logic             got_cy;
  logic [1:0]       got_st;
  bit               hold_ok, hs_ok;

  mac_host_link #(.OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .ser_a      (ser_a),
    .ser_b      (ser_b),
    .ser_valid  (ser_valid),
    .start      (start),
    .finish     (finish),
    .res_ser    (res_ser),
    .carry_in   (carry_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_status (out_status)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full transaction. The responder raises finish fin_delay cycles after
  // the start pulse and keeps it high for n_high result bits (0 = never).
  // Noise is driven on res_ser/carry_in whenever finish is low.
  task automatic do_txn(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                        input int fin_delay, input logic [RES_W-1:0] res,
                        input logic cy, input int n_high, input int rdy_wait);
    int idx;
    int guard;
    obs_sa = '0; obs_sb = '0; obs_sv = '0;
    start_cyc = -1; start_cnt = 0; valid_cyc = -1;
    got_res = '0; got_cy = 1'b0; got_st = '0;
    hold_ok = 1'b1; hs_ok = 1'b0;
    finish = 1'b0; res_ser = 1'b1; carry_in = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    in_a = a; in_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    obs_sv[0] = ser_valid;
    for (int cyc = 1; cyc <= 300 && valid_cyc < 0; cyc++) begin
      idx = (start_cyc < 0) ? -1 : cyc - (start_cyc + fin_delay);
      if (idx >= 0 && idx < n_high) begin
        finish   = 1'b1;
        res_ser  = res[idx];
        carry_in = (idx == 0) ? cy : ~cy;
      end else begin
        finish   = 1'b0;
        res_ser  = 1'b1;
        carry_in = 1'b1;
      end
      step();
      if (cyc < 16) begin
        obs_sa[cyc] = ser_a;
        obs_sb[cyc] = ser_b;
        obs_sv[cyc] = ser_valid;
      end
      if (start === 1'b1) begin
        start_cnt++;
        if (start_cyc < 0) start_cyc = cyc;
      end
      if (out_valid === 1'b1) begin
        valid_cyc = cyc;
        got_res   = out_result;
        got_cy    = out_carry;
        got_st    = out_status;
      end
    end
    if (valid_cyc >= 0) begin
      for (int k = 0; k < rdy_wait; k++) begin
        finish   = k[0];
        res_ser  = ~k[0];
        in_valid = 1'b1;
        step();
        if (out_valid !== 1'b1 || out_result !== got_res || out_carry !== got_cy ||
            out_status !== got_st || in_ready !== 1'b0 || ser_valid !== 1'b0 ||
            start !== 1'b0)
          hold_ok = 1'b0;
      end
      in_valid  = 1'b0;
      finish    = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      hs_ok = (in_ready === 1'b1) && (out_valid === 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_cmp++;
    if ({ser_a, ser_b, ser_valid, start, out_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_pins: got %b want 00000", {ser_a, ser_b, ser_valid, start, out_valid});
    end
    n_cmp++;
    if ({out_result, out_carry, out_status} !== 23'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {out_result, out_carry, out_status});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [0:7] exp_sa = 8'b1010_0101;
    logic [0:7] exp_sb = 8'b0011_1100;
    do_txn(8'hA5, 8'h3C, 5, 20'h026AC, 1'b0, 20, 0);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if ({obs_sa[k+1], obs_sb[k+1]} !== {exp_sa[k], exp_sb[k]}) begin
        n_bad++;
        $display("FAIL basic_ser_bits cycle %0d: got a=%b b=%b want a=%b b=%b",
                 k + 1, obs_sa[k+1], obs_sb[k+1], exp_sa[k], exp_sb[k]);
      end
    end
    n_cmp++;
    if (obs_sv[0:9] !== 10'b01111_11110) begin
      n_bad++;
      $display("FAIL basic_ser_valid: got %b want 0111111110", obs_sv[0:9]);
    end
    n_cmp++;
    if (start_cyc !== 9 || start_cnt !== 1) begin
      n_bad++;
      $display("FAIL basic_start: got cycle %0d count %0d want cycle 9 count 1", start_cyc, start_cnt);
    end
    n_cmp++;
    if (valid_cyc !== 34) begin
      n_bad++;
      $display("FAIL basic_latency: got out_valid cycle %0d want 34", valid_cyc);
    end
    n_cmp++;
    if ({got_res, got_cy, got_st} !== {20'h026AC, 1'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL basic_result: got %h/%b/%0d want 026ac/0/0", got_res, got_cy, got_st);
    end
    n_cmp++;
    if (hs_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_handshake: got %b want 1", hs_ok);
    end
  endtask

  task automatic test_carry_max();
    do_txn(8'hFF, 8'hFF, 1, 20'hFFFFF, 1'b1, 20, 0);
    n_cmp++;
    if ({obs_sa[1:8], obs_sb[1:8]} !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL max_ser_bits: got %h want ffff", {obs_sa[1:8], obs_sb[1:8]});
    end
    n_cmp++;
    if ({got_res, got_cy, got_st} !== {20'hFFFFF, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL max_result: got %h/%b/%0d want fffff/1/0", got_res, got_cy, got_st);
    end
    n_cmp++;
    if (valid_cyc !== 30) begin
      n_bad++;
      $display("FAIL max_latency: got out_valid cycle %0d want 30", valid_cyc);
    end
  endtask

  task automatic test_timeout();
    do_txn(8'h5A, 8'hC3, 0, 20'h0, 1'b0, 0, 0);
    n_cmp++;
    if (valid_cyc !== 25) begin
      n_bad++;
      $display("FAIL timeout_cycle: got out_valid cycle %0d want 25", valid_cyc);
    end
    n_cmp++;
    if ({got_res, got_cy, got_st} !== {20'h0, 1'b0, 2'd1}) begin
      n_bad++;
      $display("FAIL timeout_result: got %h/%b/%0d want 00000/0/1", got_res, got_cy, got_st);
    end
    do_txn(8'h12, 8'h34, 3, 20'h00408, 1'b0, 20, 0);
    n_cmp++;
    if ({got_res, got_cy, got_st} !== {20'h00408, 1'b0, 2'd0} || valid_cyc !== 32) begin
      n_bad++;
      $display("FAIL timeout_recover: got %h/%b/%0d at %0d want 00408/0/0 at 32",
               got_res, got_cy, got_st, valid_cyc);
    end
  endtask

  task automatic test_framing();
    do_txn(8'h0F, 8'hF0, 2, 20'hABCDE, 1'b1, 7, 0);
    n_cmp++;
    if (valid_cyc !== 18) begin
      n_bad++;
      $display("FAIL frame_cycle: got out_valid cycle %0d want 18", valid_cyc);
    end
    n_cmp++;
    if ({got_res, got_cy, got_st} !== {20'h0, 1'b0, 2'd2}) begin
      n_bad++;
      $display("FAIL frame_result: got %h/%b/%0d want 00000/0/2", got_res, got_cy, got_st);
    end
    do_txn(8'h01, 8'h02, 4, 20'h12345, 1'b1, 20, 0);
    n_cmp++;
    if ({got_res, got_cy, got_st} !== {20'h12345, 1'b1, 2'd0} || valid_cyc !== 33) begin
      n_bad++;
      $display("FAIL frame_recover: got %h/%b/%0d at %0d want 12345/1/0 at 33",
               got_res, got_cy, got_st, valid_cyc);
    end
  endtask

  task automatic test_backpressure();
    do_txn(8'h77, 8'h88, 2, 20'h5A5A5, 1'b0, 20, 10);
    n_cmp++;
    if ({got_res, got_cy, got_st} !== {20'h5A5A5, 1'b0, 2'd0} || valid_cyc !== 31) begin
      n_bad++;
      $display("FAIL bp_result: got %h/%b/%0d at %0d want 5a5a5/0/0 at 31",
               got_res, got_cy, got_st, valid_cyc);
    end
    n_cmp++;
    if (hold_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_hold_stable: got %b want 1", hold_ok);
    end
    n_cmp++;
    if (hs_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_handshake: got %b want 1", hs_ok);
    end
  endtask

  task automatic test_reset_mid();
    bit spurious = 1'b0;
    finish = 1'b0;
    in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    n_cmp++;
    if ({ser_valid, ser_a, ser_b} !== 3'b111) begin
      n_bad++;
      $display("FAIL rstmid_pre: got %b want 111", {ser_valid, ser_a, ser_b});
    end
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({ser_valid, ser_a, ser_b, start, out_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL rstmid_async_pins: got %b want 00000", {ser_valid, ser_a, ser_b, start, out_valid});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_in_ready: got %b want 1", in_ready);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      finish  = 1'b1;
      res_ser = k[0];
      step();
      if (out_valid !== 1'b0 || ser_valid !== 1'b0 || start !== 1'b0) spurious = 1'b1;
    end
    finish = 1'b0;
    n_cmp++;
    if (spurious !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_after_release: spurious=%b in_ready=%b want 0/1", spurious, in_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    finish    = 1'b0;
    res_ser   = 1'b0;
    carry_in  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry_max();
    test_timeout();
    test_framing();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
